// File: rtl/commit_unit_pkg.sv
// rtl/commit_unit_pkg.sv - shared types, state constants and helpers for the commit stage
package commit_unit_pkg;

   localparam int XLEN             = 32;
   localparam int ROB_SZ           = 32;
   localparam int ARCH_REG_SZ      = 32;
   localparam int PHYS_REG_SZ_R10K = 64;
   localparam int HEAD_WINDOW      = 4;

   typedef logic [XLEN-1:0]                     ADDR;
   typedef logic [XLEN-1:0]                     DATA;
   typedef logic [$clog2(ROB_SZ)-1:0]           ROB_IDX;
   typedef logic [$clog2(ARCH_REG_SZ)-1:0]      REG_IDX;
   typedef logic [$clog2(PHYS_REG_SZ_R10K)-1:0] PHYS_TAG;

   typedef enum logic [1:0] {
      NO_ERROR          = 2'd0,
      ILLEGAL_INST      = 2'd1,
      HALTED_ON_WFI     = 2'd2,
      LOAD_ACCESS_FAULT = 2'd3
   } EXCEPTION_CODE;

   typedef struct packed {
      logic          complete;
      logic          store;
      logic          halt;
      EXCEPTION_CODE exception;
      logic          is_branch;
      logic          pred_taken;
      logic          branch_taken;
      ADDR           pred_target;
      ADDR           branch_target;
      ADDR           pc;
      REG_IDX        arch_rd;
      PHYS_TAG       phys_rd;
      PHYS_TAG       prev_phys_rd;
   } ROB_ENTRY;

   typedef struct packed {
      logic   valid;
      ADDR    npc;
      DATA    data;
      REG_IDX reg_idx;
      logic   halt;
      logic   illegal;
   } COMMIT_PACKET;

   typedef logic [1:0] COMMIT_STATE;
   localparam COMMIT_STATE CS_IDLE    = 2'd0;
   localparam COMMIT_STATE CS_RECOVER = 2'd1;
   localparam COMMIT_STATE CS_HALTED  = 2'd2;

   // Per-slot summary the prefix walk needs; ready = valid and complete.
   typedef struct packed {
      logic ready;
      logic store;
      logic stops;
      logic mispredict;
   } SLOT_INFO;

   function automatic logic is_mispredict(input ROB_ENTRY e);
      return e.is_branch &&
             ((e.pred_taken != e.branch_taken) ||
              (e.branch_taken && (e.pred_target != e.branch_target)));
   endfunction

endpackage

// File: rtl/commit_unit_select.sv
// rtl/commit_unit_select.sv - combinational in-order prefix walk over the ROB head window
module commit_select
   import commit_unit_pkg::*;
#(
   parameter int N           = 4,
   parameter int RETIRE_W    = N,
   parameter int STORE_PORTS = 1,
   localparam int CW = $clog2(RETIRE_W + 1),
   localparam int SW = $clog2(STORE_PORTS + 1),
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic           enable,
   input  SLOT_INFO       slots [N],
   input  logic           sq_commit_ready,
   output logic [N-1:0]   commit_mask,
   output logic [CW-1:0]  commit_count,
   output logic [SW-1:0]  store_count,
   output logic           stop_valid,
   output logic [IW-1:0]  stop_idx,
   output logic           stop_halt
);

   localparam logic [CW-1:0] RETIRE_MAX = CW'(RETIRE_W);
   localparam logic [SW-1:0] STORE_MAX  = SW'(STORE_PORTS);

   logic walking;

   always_comb begin
      commit_mask  = '0;
      commit_count = '0;
      store_count  = '0;
      stop_valid   = 1'b0;
      stop_idx     = '0;
      stop_halt    = 1'b0;
      walking      = enable;
      for (int i = 0; i < N; i++) begin
         if (walking) begin
            if (!slots[i].ready || (commit_count == RETIRE_MAX) ||
                (slots[i].store && (!sq_commit_ready || (store_count == STORE_MAX)))) begin
               walking = 1'b0;
            end else begin
               commit_mask[i] = 1'b1;
               commit_count   = commit_count + CW'(1);
               if (slots[i].store) store_count = store_count + SW'(1);
               // Halt outranks a mispredict on the same entry: no redirect.
               if (slots[i].stops || slots[i].mispredict) begin
                  walking    = 1'b0;
                  stop_valid = 1'b1;
                  stop_idx   = IW'(i);
                  stop_halt  = slots[i].stops;
               end
            end
         end
      end
   end

endmodule

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order commit stage with store throttling, mispredict recovery and halt
module commit_unit
   import commit_unit_pkg::*;
#(
   parameter int N              = HEAD_WINDOW,
   parameter int RETIRE_W       = N,
   parameter int STORE_PORTS    = 1,
   parameter int PHYS_REGS      = PHYS_REG_SZ_R10K,
   parameter int RECOVER_CYCLES = 2,
   localparam int CW = $clog2(RETIRE_W + 1),
   localparam int SW = $clog2(STORE_PORTS + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  ROB_ENTRY             head_entries [N],
   input  logic [N-1:0]         head_valids,
   input  ROB_IDX               head_idxs [N],
   input  DATA                  regfile_entries [PHYS_REGS],
   input  logic                 sq_commit_ready,
   output logic [CW-1:0]        retire_count,
   output logic [SW-1:0]        sq_commit_count,
   output logic [N-1:0]         arch_write_enables,
   output REG_IDX               arch_write_addrs [N],
   output PHYS_TAG              arch_write_phys_regs [N],
   output logic [PHYS_REGS-1:0] free_mask,
   output logic                 redirect_valid,
   output ADDR                  redirect_pc,
   output ROB_IDX               redirect_rob_idx,
   output logic                 recovering,
   output logic                 halted,
   output COMMIT_PACKET         commit_packets [N],
   output logic [63:0]          commit_total
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = $clog2(RECOVER_CYCLES + 1);

   COMMIT_STATE          state;
   logic [TW-1:0]        recover_ctr;
   SLOT_INFO             slot_info [N];
   logic                 commit_enable;
   logic [N-1:0]         commit_mask;
   logic                 stop_valid;
   logic [IW-1:0]        stop_idx;
   logic                 stop_halt;
   ROB_ENTRY             stop_entry;
   logic                 redirect_n;
   ADDR                  redirect_target;
   logic [N-1:0]         we_n;
   REG_IDX               addr_n [N];
   PHYS_TAG              phys_n [N];
   logic [PHYS_REGS-1:0] free_n;
   COMMIT_PACKET         pkt_n [N];

   assign commit_enable = (state == CS_IDLE);
   assign recovering    = (state == CS_RECOVER);
   assign halted        = (state == CS_HALTED);

   always_comb begin
      for (int i = 0; i < N; i++) begin
         slot_info[i].ready      = head_valids[i] && head_entries[i].complete;
         slot_info[i].store      = head_entries[i].store;
         slot_info[i].stops      = head_entries[i].halt || (head_entries[i].exception == ILLEGAL_INST);
         slot_info[i].mispredict = is_mispredict(head_entries[i]);
      end
   end

   commit_select #(
      .N           (N),
      .RETIRE_W    (RETIRE_W),
      .STORE_PORTS (STORE_PORTS)
   ) u_select (
      .enable          (commit_enable),
      .slots           (slot_info),
      .sq_commit_ready (sq_commit_ready),
      .commit_mask     (commit_mask),
      .commit_count    (retire_count),
      .store_count     (sq_commit_count),
      .stop_valid      (stop_valid),
      .stop_idx        (stop_idx),
      .stop_halt       (stop_halt)
   );

   assign stop_entry      = head_entries[stop_idx];
   assign redirect_n      = stop_valid && !stop_halt;
   assign redirect_target = stop_entry.branch_taken ? stop_entry.branch_target
                                                    : stop_entry.pc + ADDR'(4);

   always_comb begin
      we_n   = '0;
      free_n = '0;
      for (int i = 0; i < N; i++) begin
         addr_n[i] = '0;
         phys_n[i] = '0;
         pkt_n[i]  = '0;
         if (commit_mask[i]) begin
            if (head_entries[i].arch_rd != '0) begin
               we_n[i]   = 1'b1;
               addr_n[i] = head_entries[i].arch_rd;
               phys_n[i] = head_entries[i].phys_rd;
               if (head_entries[i].prev_phys_rd != '0) free_n[head_entries[i].prev_phys_rd] = 1'b1;
            end
            pkt_n[i].valid   = 1'b1;
            pkt_n[i].npc     = head_entries[i].pc + ADDR'(4);
            pkt_n[i].data    = regfile_entries[head_entries[i].phys_rd];
            pkt_n[i].reg_idx = head_entries[i].arch_rd;
            pkt_n[i].halt    = head_entries[i].halt;
            pkt_n[i].illegal = (head_entries[i].exception == ILLEGAL_INST);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state                <= CS_IDLE;
         recover_ctr          <= '0;
         arch_write_enables   <= '0;
         arch_write_addrs     <= '{default: '0};
         arch_write_phys_regs <= '{default: '0};
         free_mask            <= '0;
         redirect_valid       <= 1'b0;
         redirect_pc          <= '0;
         redirect_rob_idx     <= '0;
         commit_packets       <= '{default: '0};
         commit_total         <= '0;
      end else begin
         arch_write_enables   <= we_n;
         arch_write_addrs     <= addr_n;
         arch_write_phys_regs <= phys_n;
         free_mask            <= free_n;
         commit_packets       <= pkt_n;
         redirect_valid       <= redirect_n;
         redirect_pc          <= redirect_n ? redirect_target : '0;
         redirect_rob_idx     <= redirect_n ? head_idxs[stop_idx] : '0;
         commit_total         <= commit_total + 64'(retire_count);
         case (state)
            CS_IDLE: begin
               if (stop_valid && stop_halt) begin
                  state <= CS_HALTED;
               end else if (stop_valid) begin
                  state       <= CS_RECOVER;
                  recover_ctr <= TW'(RECOVER_CYCLES - 1);
               end
            end
            CS_RECOVER: begin
               if (recover_ctr == '0) state <= CS_IDLE;
               else                   recover_ctr <= recover_ctr - TW'(1);
            end
            default: state <= CS_HALTED;
         endcase
      end
   end

endmodule

// File: tb/tb_commit_unit.sv
// tb/tb_commit_unit.sv - directed and randomized checks of commit_unit against a reference model
module tb_commit_unit;
   import commit_unit_pkg::*;

   localparam int N  = 4;
   localparam int RW = 4;
   localparam int SP = 1;
   localparam int PR = PHYS_REG_SZ_R10K;
   localparam int RC = 2;

   logic clock = 1'b0;
   logic reset;
   ROB_ENTRY ents [N];
   logic [N-1:0] valids;
   ROB_IDX idxs [N];
   DATA rf [PR];
   logic sq_ready;

   logic [2:0]    retire_count;
   logic [0:0]    sq_commit_count;
   logic [N-1:0]  arch_write_enables;
   REG_IDX        arch_write_addrs [N];
   PHYS_TAG       arch_write_phys_regs [N];
   logic [PR-1:0] free_mask;
   logic          redirect_valid;
   ADDR           redirect_pc;
   ROB_IDX        redirect_rob_idx;
   logic          recovering;
   logic          halted;
   COMMIT_PACKET  commit_packets [N];
   logic [63:0]   commit_total;

   commit_unit #(
      .N(N), .RETIRE_W(RW), .STORE_PORTS(SP), .PHYS_REGS(PR), .RECOVER_CYCLES(RC)
   ) dut (
      .clock(clock), .reset(reset),
      .head_entries(ents), .head_valids(valids), .head_idxs(idxs),
      .regfile_entries(rf), .sq_commit_ready(sq_ready),
      .retire_count(retire_count), .sq_commit_count(sq_commit_count),
      .arch_write_enables(arch_write_enables), .arch_write_addrs(arch_write_addrs),
      .arch_write_phys_regs(arch_write_phys_regs), .free_mask(free_mask),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .redirect_rob_idx(redirect_rob_idx), .recovering(recovering), .halted(halted),
      .commit_packets(commit_packets), .commit_total(commit_total)
   );

   always #5 clock = ~clock;

   int compared = 0;
   int mismatched = 0;

   // Reference model: cycles of blocking left, sticky halt, running total.
   int              rec_left;
   bit              m_halted;
   longint unsigned m_total;
   logic [N-1:0]    exp_we;
   logic [PR-1:0]   exp_free;
   logic            exp_rv;
   ADDR             exp_rpc;
   ROB_IDX          exp_ridx;
   COMMIT_PACKET    exp_pk [N];
   int              obs_rc;
   int              obs_sq;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_mispredict(input ROB_ENTRY e);
      if (!e.is_branch) return 1'b0;
      if (e.pred_taken != e.branch_taken) return 1'b1;
      return e.branch_taken && (e.pred_target != e.branch_target);
   endfunction

   task automatic ref_walk(output int n, output int st, output bit hs, output bit mp);
      n = 0; st = 0; hs = 1'b0; mp = 1'b0;
      if (m_halted || rec_left > 0) return;
      for (int i = 0; i < N; i++) begin
         if (!valids[i] || !ents[i].complete || n == RW) break;
         if (ents[i].store) begin
            if (!sq_ready || st == SP) break;
            st++;
         end
         n++;
         if (ents[i].halt || ents[i].exception == ILLEGAL_INST) begin hs = 1'b1; break; end
         if (ref_mispredict(ents[i])) begin mp = 1'b1; break; end
      end
   endtask

   // Entered at a falling edge with inputs already driven; leaves at the next falling edge.
   task automatic step();
      int n, st;
      bit hs, mp;
      ROB_ENTRY e;
      ref_walk(n, st, hs, mp);
      #1;
      check("retire_count", 128'(retire_count), 128'(n));
      check("sq_commit_count", 128'(sq_commit_count), 128'(st));
      check("recovering", 128'(recovering), 128'(rec_left > 0));
      check("halted", 128'(halted), 128'(m_halted));
      obs_rc = int'(retire_count);
      obs_sq = int'(sq_commit_count);
      exp_we = '0; exp_free = '0; exp_rv = 1'b0; exp_rpc = '0; exp_ridx = '0;
      for (int i = 0; i < N; i++) begin
         exp_pk[i] = '0;
         if (i < n) begin
            e = ents[i];
            if (e.arch_rd != 0) begin
               exp_we[i] = 1'b1;
               if (e.prev_phys_rd != 0) exp_free[e.prev_phys_rd] = 1'b1;
            end
            exp_pk[i] = '{valid: 1'b1, npc: e.pc + 32'd4, data: rf[e.phys_rd],
                          reg_idx: e.arch_rd, halt: e.halt, illegal: e.exception == ILLEGAL_INST};
         end
      end
      if (mp) begin
         e = ents[n-1];
         exp_rv   = 1'b1;
         exp_rpc  = e.branch_taken ? e.branch_target : e.pc + 32'd4;
         exp_ridx = idxs[n-1];
      end
      m_total += longint'(n);
      if (hs)                m_halted = 1'b1;
      else if (mp)           rec_left = RC;
      else if (rec_left > 0) rec_left--;
      @(posedge clock); #1;
      check("arch_write_enables", 128'(arch_write_enables), 128'(exp_we));
      check("free_mask", 128'(free_mask), 128'(exp_free));
      check("redirect_valid", 128'(redirect_valid), 128'(exp_rv));
      check("redirect_pc", 128'(redirect_pc), 128'(exp_rpc));
      check("redirect_rob_idx", 128'(redirect_rob_idx), 128'(exp_ridx));
      check("commit_total", 128'(commit_total), 128'(m_total));
      for (int i = 0; i < N; i++) check("commit_packet", 128'(commit_packets[i]), 128'(exp_pk[i]));
      @(negedge clock);
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      @(posedge clock); #1;
      check("rst_we", 128'(arch_write_enables), 128'(0));
      check("rst_free", 128'(free_mask), 128'(0));
      check("rst_rv", 128'(redirect_valid), 128'(0));
      check("rst_rpc", 128'(redirect_pc), 128'(0));
      check("rst_total", 128'(commit_total), 128'(0));
      check("rst_halted", 128'(halted), 128'(0));
      check("rst_recovering", 128'(recovering), 128'(0));
      for (int i = 0; i < N; i++) check("rst_pkt_valid", 128'(commit_packets[i].valid), 128'(0));
      rec_left = 0; m_halted = 1'b0; m_total = 0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   function automatic ROB_ENTRY mk(input int rd, input int prd, input int prev);
      ROB_ENTRY e = '0;
      e.complete     = 1'b1;
      e.arch_rd      = REG_IDX'(rd);
      e.phys_rd      = PHYS_TAG'(prd);
      e.prev_phys_rd = PHYS_TAG'(prev);
      e.pc           = 32'h100 + 32'(rd * 4);
      return e;
   endfunction

   function automatic ROB_ENTRY rand_entry();
      ROB_ENTRY e = '0;
      e.complete      = ($urandom_range(9) != 0);
      e.store         = ($urandom_range(3) == 0);
      e.halt          = ($urandom_range(59) == 0);
      e.exception     = ($urandom_range(59) == 0) ? ILLEGAL_INST : NO_ERROR;
      e.is_branch     = !e.store && ($urandom_range(2) == 0);
      e.pred_taken    = 1'($urandom);
      e.branch_taken  = 1'($urandom);
      e.branch_target = ADDR'($urandom) & 32'hFFFF_FFFC;
      e.pred_target   = ($urandom_range(1) == 0) ? e.branch_target : (ADDR'($urandom) & 32'hFFFF_FFFC);
      e.pc            = ADDR'($urandom) & 32'hFFFF_FFFC;
      e.arch_rd       = ($urandom_range(4) == 0) ? REG_IDX'(0) : REG_IDX'($urandom);
      e.phys_rd       = PHYS_TAG'($urandom);
      e.prev_phys_rd  = ($urandom_range(5) == 0) ? PHYS_TAG'(0) : PHYS_TAG'($urandom);
      return e;
   endfunction

   task automatic plain_window();
      for (int i = 0; i < N; i++) begin
         ents[i] = mk(i + 1, 10 + i, 40 + i);
         idxs[i] = ROB_IDX'(8 + i);
      end
      valids   = '1;
      sq_ready = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < PR; i++) rf[i] = DATA'($urandom);
      plain_window();
      reset_dut();

      // Four plain commits.
      plain_window();
      step();
      check("tp_all4_rc", 128'(obs_rc), 128'(4));
      check("tp_all4_free", 128'(free_mask), 128'(64'h0000_0F00_0000_0000));
      check("tp_all4_total", 128'(commit_total), 128'(4));

      // Slot 1 incomplete.
      plain_window();
      ents[1].complete = 1'b0;
      step();
      check("tp_incomplete_rc", 128'(obs_rc), 128'(1));
      check("tp_incomplete_we", 128'(arch_write_enables), 128'(4'b0001));

      // Store throttling.
      plain_window();
      for (int i = 0; i < N; i++) begin ents[i].store = 1'b1; ents[i].arch_rd = '0; end
      step();
      check("tp_store_rc", 128'(obs_rc), 128'(1));
      check("tp_store_sq", 128'(obs_sq), 128'(1));
      sq_ready = 1'b0;
      step();
      check("tp_store_blocked_rc", 128'(obs_rc), 128'(0));

      // Mispredicted taken branch in slot 1.
      plain_window();
      ents[1].is_branch = 1'b1; ents[1].branch_taken = 1'b1; ents[1].pred_taken = 1'b0;
      ents[1].branch_target = 32'h200;
      step();
      check("tp_mp_rc", 128'(obs_rc), 128'(2));
      check("tp_mp_rv", 128'(redirect_valid), 128'(1));
      check("tp_mp_rpc", 128'(redirect_pc), 128'(32'h200));
      plain_window();
      step();
      check("tp_mp_block1", 128'(obs_rc), 128'(0));
      step();
      check("tp_mp_block2", 128'(obs_rc), 128'(0));
      check("tp_mp_idle_t3", 128'(recovering), 128'(0));
      step();
      check("tp_mp_resume", 128'(obs_rc), 128'(4));

      // Halt in slot 2.
      plain_window();
      ents[2].halt = 1'b1;
      step();
      check("tp_halt_rc", 128'(obs_rc), 128'(3));
      check("tp_halt_halted", 128'(halted), 128'(1));
      plain_window();
      step();
      check("tp_halt_stuck", 128'(obs_rc), 128'(0));
      reset_dut();

      // Reset in the middle of recovery.
      plain_window();
      ents[0].is_branch = 1'b1; ents[0].pred_taken = 1'b1; ents[0].branch_taken = 1'b0;
      step();
      check("tp_rr_recovering", 128'(recovering), 128'(1));
      reset_dut();
      plain_window();
      step();
      check("tp_rr_resume", 128'(obs_rc), 128'(4));

      // Randomized window traffic.
      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < N; i++) begin
            ents[i] = rand_entry();
            idxs[i] = ROB_IDX'($urandom);
         end
         valids   = N'($urandom) | N'($urandom);
         sq_ready = ($urandom_range(3) != 0);
         if (($urandom_range(39) == 0) || (m_halted && $urandom_range(3) == 0)) reset_dut();
         else step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/commit_unit.md
# commit_unit

Parametrised in-order commit stage that sits between the ROB head window and the architectural state: the arch map table, freelist, store queue, fetch redirect and debug counters. It retires up to `RETIRE_W` complete head entries per cycle. It limits store commits to the store-queue drain bandwidth, and registers all architectural side effects. A recovery state machine blocks commit for a programmable number of cycles after a mispredict, and the block latches a halted state on `halt` or an illegal instruction.

## Interface
- `N`, `` `N ``: ROB head window width.
- `RETIRE_W`, `N`: maximum commits per cycle, 1..N.
- `STORE_PORTS`, 1: maximum stores committed per cycle.
- `PHYS_REGS`, `` `PHYS_REG_SZ_R10K ``: physical register count.
- `RECOVER_CYCLES`, 2: commit-blocked cycles after a redirect, ≥1.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `head_entries` in `ROB_ENTRY[N]`: index 0 is the oldest.
- `head_valids` in N: per-slot valid.
- `head_idxs` in `ROB_IDX[N]`: ROB index per slot.
- `regfile_entries` in `DATA[PHYS_REGS]`: PRF contents, used for debug data.
- `sq_commit_ready` in 1: the store queue accepts store commits this cycle.
- `retire_count` out `$clog2(RETIRE_W+1)`: combinational; number of entries the ROB pops this cycle.
- `sq_commit_count` out `$clog2(STORE_PORTS+1)`: combinational; stores committed this cycle.
- `arch_write_enables/addrs/phys_regs` out `N`/`REG_IDX[N]`/`PHYS_TAG[N]`: registered.
- `free_mask` out `PHYS_REGS`: registered.
- `redirect_valid` out 1: registered one-cycle pulse.
- `redirect_pc` out `ADDR`: registered.
- `redirect_rob_idx` out `ROB_IDX`: registered.
- `recovering` out 1: state ≠ IDLE and ≠ HALTED.
- `halted` out 1: sticky.
- `commit_packets` out `COMMIT_PACKET[N]`: registered debug output.
- `commit_total` out 64: registered running count of committed instructions.

## Operation
- FSM states: IDLE, RECOVER, HALTED. Commit occurs only in IDLE.
- Commit walk, combinational in cycle t. Scan slots 0..N-1 and stop at the first slot that meets any of these conditions:
  - the slot is not valid;
  - the slot is not `complete`;
  - `RETIRE_W` entries have already been committed;
  - the slot is a store and either `sq_commit_ready`=0 or `STORE_PORTS` stores have already been committed.
- Each committed slot w produces:
  - an arch write if `arch_rd`≠0;
  - a free of `prev_phys_rd` if `arch_rd`≠0 and `prev_phys_rd`≠0;
  - a commit packet with NPC=PC+4, data=`regfile_entries[phys_rd]`, reg_idx, halt, illegal, and valid=1.
- Committed slots are a contiguous prefix; `retire_count` equals the prefix length.
- Mispredict: a committed branch with `pred_taken`≠`branch_taken`, or taken with `pred_target`≠`branch_target`.
  - The branch itself commits and the walk stops after it.
  - The redirect target is `branch_target` if taken, else PC+4.
  - In cycle t+1: `redirect_valid`=1 with `redirect_pc` and `redirect_rob_idx`, and state=RECOVER with the counter loaded to `RECOVER_CYCLES`-1.
- RECOVER decrements the counter each cycle and returns to IDLE the cycle after the counter reaches 0. While in RECOVER, `retire_count`=0 regardless of the head window.
- A committed entry with `halt`, or with `exception`==ILLEGAL_INST, commits itself, stops the walk, and moves the FSM to HALTED. HALTED is left only by reset.
- If a halt entry is also a mispredicting branch, halt wins: no redirect is issued.
- `commit_total` accumulates `retire_count` with a 64-bit wrap.

## Timing
- Effects of cycle t (arch writes, free mask, packets, redirect, counter) appear at t+1. All registered outputs return to 0 in any cycle with no commit.
- Reset: all registered outputs are 0, state=IDLE, the counter is 0, and `halted`=0. Reset in the middle of RECOVER aborts to IDLE the next cycle.
- `retire_count` and `sq_commit_count` are valid in the same cycle and depend only on current inputs and state.
- RECOVER lasts exactly `RECOVER_CYCLES` cycles, measured from t+1.

## Structure
- `ROB_ENTRY`, `ROB_IDX`, `PHYS_TAG`, `REG_IDX`, `COMMIT_PACKET`, `ADDR`, `DATA`, and `ILLEGAL_INST` come from `sys_defs`.
- Add `ROB_ENTRY.store` and the `COMMIT_STATE` enum to `sys_defs`.
- Natural sub-module: `commit_select`, the combinational prefix walk. It produces the commit mask, the store count, and the index and type of the stop event.

## Test plan
- N=4, all 4 valid and complete, no stores, arch_rd=1..4, prev_phys_rd=40..43:
  - `retire_count`=4 in the same cycle;
  - at t+1, `free_mask` bits 40..43 are set and `commit_total`=4.
- Slot 1 incomplete: `retire_count`=1; only `arch_write_enables[0]` is set at t+1.
- Stores in slots 0 and 1, STORE_PORTS=1:
  - with `sq_commit_ready`=1: `retire_count`=1, `sq_commit_count`=1;
  - with `sq_commit_ready`=0: `retire_count`=0.
- Slot 1 is a mispredicted taken branch to 0x200, RECOVER_CYCLES=2:
  - `retire_count`=2;
  - at t+1, `redirect_valid`=1 and `redirect_pc`=0x200;
  - `retire_count`=0 during t+1..t+2 despite complete heads;
  - IDLE at t+3.
- Slot 2 has `halt`: `retire_count`=3, then `halted`=1; no further commits until reset, after which state=IDLE.
- Reset asserted during RECOVER: the next cycle shows all outputs 0, `recovering`=0, and commit resumes.
